// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - 24-hour time-of-day counter with 1 Hz prescaler and per-field set/adjust
module time_keeper #(
  parameter int CLK_HZ = 50_000_000,
  parameter int WIDTH  = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       flash_mode,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] hours,
  output logic [WIDTH-1:0] mins,
  output logic [WIDTH-1:0] secs,
  output logic             tick,
  output logic             day_wrap
);

  localparam int PW = $clog2(CLK_HZ);

  localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [WIDTH-1:0] SEC_MAX  = WIDTH'(59);
  localparam logic [WIDTH-1:0] MIN_MAX  = WIDTH'(59);
  localparam logic [WIDTH-1:0] HOUR_MAX = WIDTH'(23);

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_SECS  = 2'b01,
    MODE_MINS  = 2'b10,
    MODE_HOURS = 2'b11
  } mode_e;

  mode_e            mode;
  logic [PW-1:0]    pre;
  logic [PW-1:0]    pre_n;
  logic [WIDTH-1:0] secs_n;
  logic [WIDTH-1:0] mins_n;
  logic [WIDTH-1:0] hours_n;
  logic             tick_n;
  logic             wrap_n;
  logic             adjust;

  assign mode   = mode_e'(flash_mode);
  // Simultaneous inc and dec cancel out.
  assign adjust = inc ^ dec;

  // Up-step with wrap at max; anything at or above max (including illegal values) lands on 0.
  function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] v,
                                              input logic [WIDTH-1:0] max);
    if (v >= max) return '0;
    return v + WIDTH'(1);
  endfunction

  // Down-step with wrap from 0 to max; illegal values above max are forced to 0.
  function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] max);
    if (v == '0) return max;
    if (v > max) return '0;
    return v - WIDTH'(1);
  endfunction

  // Adjusts the selected field by one in the direction of the pulse.
  function automatic logic [WIDTH-1:0] nudge(input logic [WIDTH-1:0] v,
                                            input logic [WIDTH-1:0] max,
                                            input logic up);
    return up ? step_up(v, max) : step_down(v, max);
  endfunction

  // Next-state: prescaler and carry chain in run mode, single-field adjust in set modes.
  always_comb begin
    pre_n   = pre;
    secs_n  = secs;
    mins_n  = mins;
    hours_n = hours;
    tick_n  = 1'b0;
    wrap_n  = 1'b0;
    if (mode == MODE_RUN) begin
      if (pre >= PRE_LAST) begin
        pre_n  = '0;
        tick_n = 1'b1;
        secs_n = step_up(secs, SEC_MAX);
        if (secs >= SEC_MAX) begin
          mins_n = step_up(mins, MIN_MAX);
          if (mins >= MIN_MAX) begin
            hours_n = step_up(hours, HOUR_MAX);
            wrap_n  = (hours >= HOUR_MAX);
          end
        end
      end else begin
        pre_n = pre + PW'(1);
      end
    end else begin
      // Set modes discard any partial second so the next run starts a full second.
      pre_n = '0;
      if (adjust) begin
        case (mode)
          MODE_SECS:  secs_n  = nudge(secs,  SEC_MAX,  inc);
          MODE_MINS:  mins_n  = nudge(mins,  MIN_MAX,  inc);
          MODE_HOURS: hours_n = nudge(hours, HOUR_MAX, inc);
          default:    ;
        endcase
      end
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre      <= '0;
      secs     <= '0;
      mins     <= '0;
      hours    <= '0;
      tick     <= 1'b0;
      day_wrap <= 1'b0;
    end else begin
      pre      <= pre_n;
      secs     <= secs_n;
      mins     <= mins_n;
      hours    <= hours_n;
      tick     <= tick_n;
      day_wrap <= wrap_n;
    end
  end

endmodule
